inst_prefetch_buffer: RTL and testbench

//   Instruction-fetch front end, directly upstream of the boot ROM slave port.

---
 rtl/inst_prefetch_buffer.sv | 142 ++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - sequential instruction prefetcher with Avalon read master and FWFT {PC, inst} queue
// Optional fetch/discard counters are enabled with `define PREFETCH_STATS_EN.
module inst_prefetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    output logic [31:0] o_AV_Addr,
    output logic        o_AV_Read,
    input  logic [31:0] i_AV_ReadData,
    input  logic        i_AV_WaitRequest,
    input  logic        i_Redirect,
    input  logic [31:0] i_Redirect_PC,
    output logic        o_Inst_Valid,
    output logic [31:0] o_Inst,
    output logic [31:0] o_Inst_PC,
    input  logic        i_Inst_Ready
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] o_Stat_Fetches,
    output logic [31:0] o_Stat_Discards
`endif
);

    localparam int          AW         = $clog2(DEPTH);
    localparam int          CW         = AW + 1;
    localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_fly_pc;
    logic          r_inflight;
    logic          r_discard;
    logic          r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_last_inst;
    logic [31:0]   r_last_pc;
    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];

    logic [CW:0]   w_occ;
    logic          w_credit;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_redirect_pc;

    // Credit counts queued entries plus the response in flight; a same-cycle pop is not credited.
    assign w_occ         = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign w_credit      = w_occ < (CW+1)'(DEPTH);
    assign o_AV_Read     = w_credit & ~r_drop & ~i_Reset;
    assign o_AV_Addr     = r_fetch_pc;
    assign w_accept      = o_AV_Read & ~i_AV_WaitRequest;
    assign w_redirect_pc = i_Redirect_PC & 32'hFFFF_FFFC;
    assign w_push        = r_inflight & ~r_discard & ~i_Redirect;
    assign w_pop         = (r_count != '0) & i_Inst_Ready & ~i_Redirect;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_fetch_pc <= RESET_PC_W;
            r_fly_pc   <= '0;
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            r_fly_pc   <= r_fetch_pc;
            r_discard  <= i_Redirect & w_accept;
            // A stalled request is abandoned for one cycle so the address never changes under a held read.
            r_drop     <= i_Redirect & o_AV_Read & i_AV_WaitRequest;
            if (i_Redirect) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= i_AV_ReadData;
            r_mem_pc[r_wr_ptr]   <= r_fly_pc;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_inst <= '0;
            r_last_pc   <= '0;
        end else begin
            if (r_count != '0) begin
                r_last_inst <= r_mem_inst[r_rd_ptr];
                r_last_pc   <= r_mem_pc[r_rd_ptr];
            end
            if (i_Redirect) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    assign o_Inst_Valid = (r_count != '0);
    assign o_Inst       = o_Inst_Valid ? r_mem_inst[r_rd_ptr] : r_last_inst;
    assign o_Inst_PC    = o_Inst_Valid ? r_mem_pc[r_rd_ptr]   : r_last_pc;

`ifdef PREFETCH_STATS_EN
    logic [31:0] r_stat_fetches;
    logic [31:0] r_stat_discards;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_stat_fetches  <= '0;
            r_stat_discards <= '0;
        end else begin
            if (w_accept) begin
                r_stat_fetches <= r_stat_fetches + 32'd1;
            end
            if (r_inflight & (r_discard | i_Redirect)) begin
                r_stat_discards <= r_stat_discards + 32'd1;
            end
        end
    end

    assign o_Stat_Fetches  = r_stat_fetches;
    assign o_Stat_Discards = r_stat_discards;
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - self-checking bench for inst_prefetch_buffer
module tb_inst_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] K        = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] av_addr;
    logic        av_read;
    logic [31:0] av_rdata;
    logic        av_wait;
    logic        redir;
    logic [31:0] redir_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef PREFETCH_STATS_EN
    logic [31:0] st_fetch;
    logic [31:0] st_disc;
`endif

    always #5 clk = ~clk;

    inst_prefetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
`ifdef PREFETCH_STATS_EN
        .o_Stat_Fetches   (st_fetch),
        .o_Stat_Discards  (st_disc),
`endif
        .i_Clk            (clk),
        .i_Reset          (rst),
        .o_AV_Addr        (av_addr),
        .o_AV_Read        (av_read),
        .i_AV_ReadData    (av_rdata),
        .i_AV_WaitRequest (av_wait),
        .i_Redirect       (redir),
        .i_Redirect_PC    (redir_pc),
        .o_Inst_Valid     (inst_valid),
        .o_Inst           (inst),
        .o_Inst_PC        (inst_pc),
        .i_Inst_Ready     (inst_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        rst, rdy, wt;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    // Reference model: a queue of pending instructions plus the one response on the bus.
    ent_t        m_q[$];
    logic [31:0] m_pc, m_fly_pc, m_last_inst, m_last_pc;
    bit          m_fly, m_fly_drop, m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_pc        = RESET_PC;
        m_fly       = 1'b0;
        m_fly_drop  = 1'b0;
        m_fly_pc    = '0;
        m_drop      = 1'b0;
        m_last_inst = '0;
        m_last_pc   = '0;
    endfunction

    function automatic bit m_read();
        return !rst && !m_drop && ((m_q.size() + int'(m_fly)) < DEPTH);
    endfunction

    task automatic drive(input logic r, input logic rdy, input logic w, input logic rd, input logic [31:0] rpc);
        rst        = r;
        inst_ready = rdy;
        av_wait    = w;
        redir      = rd;
        redir_pc   = rpc;
    endtask

    // One clock: compare against the model, advance the model, play the memory slave.
    task automatic tick();
        bit          rd, acc, dut_acc;
        bit          s_rst, s_rdy, s_wt, s_redir;
        logic [31:0] s_rpc, s_addr, dut_addr;
        ent_t        e;
        #1;
        rd = m_read();
        chk1("m_read", av_read, rd);
        chk("m_addr", av_addr, m_pc);
        chk1("m_valid", inst_valid, m_q.size() > 0);
        chk("m_inst", inst, (m_q.size() > 0) ? m_q[0].inst : m_last_inst);
        chk("m_inst_pc", inst_pc, (m_q.size() > 0) ? m_q[0].pc : m_last_pc);
        s_rst = rst; s_rdy = inst_ready; s_wt = av_wait; s_redir = redir; s_rpc = redir_pc;
        s_addr   = m_pc;
        acc      = rd && !s_wt;
        dut_acc  = av_read && !av_wait;
        dut_addr = av_addr;
        @(posedge clk);
        if (s_rst) begin
            m_reset();
        end else begin
            if (m_q.size() > 0) begin
                m_last_inst = m_q[0].inst;
                m_last_pc   = m_q[0].pc;
            end
            if (s_redir) begin
                m_drop     = rd && s_wt;
                m_q.delete();
                m_fly      = acc;
                m_fly_drop = 1'b1;
                m_fly_pc   = s_addr;
                m_pc       = s_rpc & 32'hFFFF_FFFC;
            end else begin
                m_drop = 1'b0;
                if (s_rdy && m_q.size() > 0) void'(m_q.pop_front());
                if (m_fly && !m_fly_drop) begin
                    e.pc   = m_fly_pc;
                    e.inst = m_fly_pc ^ K;
                    m_q.push_back(e);
                    chk1("no_overflow", m_q.size() <= DEPTH, 1'b1);
                end
                m_fly      = acc;
                m_fly_drop = 1'b0;
                m_fly_pc   = s_addr;
                if (acc) m_pc = m_pc + 32'd4;
            end
        end
        #1;
        av_rdata = dut_acc ? (dut_addr ^ K) : $urandom;
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic wt, input logic e_read,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.wt = wt; v.e_read = e_read; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    vec_t tbl[30];

    initial begin
        bit found;
`ifdef PREFETCH_STATS_EN
        logic [31:0] d0;
`endif
        // Streaming with ready, reset mid-stream, fill with ready low, drain, then a 3-cycle stall on addr 8.
        tbl[0]  = mk(1,1,0, 0,32'd0, 0,32'd0, 32'h0);
        tbl[1]  = mk(0,1,0, 1,32'd0, 0,32'd0, 32'h0);
        tbl[2]  = mk(0,1,0, 1,32'd4, 0,32'd0, 32'h0);
        tbl[3]  = mk(0,1,0, 1,32'd8, 1,32'd0, 32'hA5A5_A5A5);
        tbl[4]  = mk(0,1,0, 1,32'd12,1,32'd4, 32'hA5A5_A5A1);
        tbl[5]  = mk(0,1,0, 1,32'd16,1,32'd8, 32'hA5A5_A5AD);
        tbl[6]  = mk(1,0,0, 0,32'd20,1,32'd12,32'hA5A5_A5A9);
        tbl[7]  = mk(1,0,0, 0,32'd0, 0,32'd0, 32'h0);
        tbl[8]  = mk(0,0,0, 1,32'd0, 0,32'd0, 32'h0);
        tbl[9]  = mk(0,0,0, 1,32'd4, 0,32'd0, 32'h0);
        tbl[10] = mk(0,0,0, 1,32'd8, 1,32'd0, 32'hA5A5_A5A5);
        tbl[11] = mk(0,0,0, 1,32'd12,1,32'd0, 32'hA5A5_A5A5);
        tbl[12] = mk(0,0,0, 0,32'd16,1,32'd0, 32'hA5A5_A5A5);
        tbl[13] = mk(0,0,0, 0,32'd16,1,32'd0, 32'hA5A5_A5A5);
        tbl[14] = mk(0,1,0, 0,32'd16,1,32'd0, 32'hA5A5_A5A5);
        tbl[15] = mk(0,1,0, 1,32'd16,1,32'd4, 32'hA5A5_A5A1);
        tbl[16] = mk(0,1,0, 1,32'd20,1,32'd8, 32'hA5A5_A5AD);
        tbl[17] = mk(0,1,0, 1,32'd24,1,32'd12,32'hA5A5_A5A9);
        tbl[18] = mk(0,1,0, 1,32'd28,1,32'd16,32'hA5A5_A5B5);
        tbl[19] = mk(1,1,0, 0,32'd32,1,32'd20,32'hA5A5_A5B1);
        tbl[20] = mk(1,1,0, 0,32'd0, 0,32'd0, 32'h0);
        tbl[21] = mk(0,1,0, 1,32'd0, 0,32'd0, 32'h0);
        tbl[22] = mk(0,1,0, 1,32'd4, 0,32'd0, 32'h0);
        tbl[23] = mk(0,1,1, 1,32'd8, 1,32'd0, 32'hA5A5_A5A5);
        tbl[24] = mk(0,1,1, 1,32'd8, 1,32'd4, 32'hA5A5_A5A1);
        tbl[25] = mk(0,1,1, 1,32'd8, 0,32'd4, 32'hA5A5_A5A1);
        tbl[26] = mk(0,1,0, 1,32'd8, 0,32'd4, 32'hA5A5_A5A1);
        tbl[27] = mk(0,1,0, 1,32'd12,0,32'd4, 32'hA5A5_A5A1);
        tbl[28] = mk(0,1,0, 1,32'd16,1,32'd8, 32'hA5A5_A5AD);
        tbl[29] = mk(0,1,0, 1,32'd20,1,32'd12,32'hA5A5_A5A9);

        av_rdata = '0;
        drive(1, 0, 0, 0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        m_reset();

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].wt, 1'b0, 32'h0);
            #1;
            chk1($sformatf("tbl%0d_read", i), av_read, tbl[i].e_read);
            chk($sformatf("tbl%0d_addr", i), av_addr, tbl[i].e_addr);
            chk1($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_inst", i), inst, tbl[i].e_inst);
            tick();
        end

        // Redirect to 0x103 with a read in flight, one being accepted and two queued.
        drive(1, 0, 0, 0, 32'h0); tick(); tick();
        drive(0, 0, 0, 0, 32'h0); tick(); tick(); tick();
        drive(0, 0, 0, 1, 32'h0000_0103); tick();
        drive(0, 1, 0, 0, 32'h0);
        #1;
        chk1("t4_valid_low", inst_valid, 1'b0);
        chk1("t4_read", av_read, 1'b1);
        chk("t4_addr", av_addr, 32'h0000_0100);
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            if (inst_valid) begin
                found = 1'b1;
                chk("t4_first_pc", inst_pc, 32'h0000_0100);
                chk("t4_first_inst", inst, 32'h0000_0100 ^ K);
            end else begin
                tick();
                #1;
            end
        end
        if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL t4_timeout: no valid instruction within 8 cycles after redirect");
        end

        // Redirect with simultaneous pop while credits are exhausted.
        drive(1, 0, 0, 0, 32'h0); tick(); tick();
        drive(0, 0, 0, 0, 32'h0); tick(); tick(); tick(); tick();
`ifdef PREFETCH_STATS_EN
        d0 = st_disc;
`endif
        drive(0, 1, 0, 1, 32'h0000_0200); tick();
        drive(0, 1, 0, 0, 32'h0);
        #1;
        chk1("t5_valid_low", inst_valid, 1'b0);
        chk("t5_addr", av_addr, 32'h0000_0200);
`ifdef PREFETCH_STATS_EN
        chk("t5_discards", st_disc - d0, 32'd1);
`endif
        repeat (5) tick();

        // Redirect while a read is stalled: read drops for one cycle, then resumes at the new PC.
        drive(0, 0, 1, 0, 32'h0); tick(); tick();
        drive(0, 0, 1, 1, 32'h0000_0300); tick();
        drive(0, 0, 0, 0, 32'h0);
        #1;
        chk1("stall_redir_drop", av_read, 1'b0);
        chk("stall_redir_addr", av_addr, 32'h0000_0300);
        tick();
        #1;
        chk1("stall_redir_resume", av_read, 1'b1);

        // Back-to-back redirects, then wrap across the top of the address space.
        drive(0, 1, 0, 1, 32'h0000_0400); tick();
        drive(0, 1, 0, 1, 32'h0000_0502); tick();
        drive(0, 1, 0, 0, 32'h0);
        #1;
        chk("b2b_addr", av_addr, 32'h0000_0500);
        repeat (4) tick();
        drive(0, 1, 0, 1, 32'hFFFF_FFF8); tick();
        drive(0, 1, 0, 0, 32'h0);
        tick(); tick();
        #1;
        chk("wrap_addr", av_addr, 32'h0000_0000);
        repeat (4) tick();

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 24) == 0,
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
